// File: rtl/servo_track_axis_pkg.sv
// Shared definitions for the per-axis servo trackers: FSM encoding and
// the default limit/timing constants used by both the X and Y instances.
package servo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC1 = 2'd1,
        ST_CALC2 = 2'd2,
        ST_CLAMP = 2'd3
    } state_t;

    localparam int DEF_PWM_MIN    = 800;
    localparam int DEF_PWM_MAX    = 2300;
    localparam int DEF_PWM_INIT   = 1500;
    localparam int DEF_CLK_PER_US = 100;
    localparam int DEF_PERIOD_US  = 20000;

endpackage

// File: rtl/servo_track_axis_if.sv
// Frame-side inputs and servo-side outputs of one tracker axis.
interface servo_track_axis_if #(
    parameter int COORD_W = 11,
    parameter int ADC_W   = 12,
    parameter int THR_W   = 15
);
    logic               vsync;
    logic               obj_valid;
    logic [COORD_W-1:0] obj_coord;
    logic               fb_valid;
    logic [ADC_W-1:0]   fb_pos;
    logic [THR_W-1:0]   pwm_thres;
    logic               pwm_out;
    logic               searching;
    logic               upd;

    modport master (
        output vsync, obj_valid, obj_coord, fb_valid, fb_pos,
        input  pwm_thres, pwm_out, searching, upd
    );

    modport slave (
        input  vsync, obj_valid, obj_coord, fb_valid, fb_pos,
        output pwm_thres, pwm_out, searching, upd
    );
endinterface

// File: rtl/servo_track_axis_pwm_out.sv
// Servo PWM generator: microsecond prescaler, period counter and a shadow
// threshold that only reloads at the period wrap so pulses are never cut short.
module servo_pwm_out #(
    parameter int THR_W      = 15,
    parameter int CLK_PER_US = 100,
    parameter int PERIOD_US  = 20000,
    parameter int PWM_INIT   = 1500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [THR_W-1:0] i_thres,
    output logic             o_pwm
);
    localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int US_W  = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam int CMP_W = (US_W > THR_W) ? US_W : THR_W;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);
    localparam logic [US_W-1:0]  US_LAST  = US_W'(PERIOD_US - 1);

    logic [PRE_W-1:0] r_pre;
    logic [US_W-1:0]  r_us;
    logic [THR_W-1:0] r_shadow;

    // Count clocks into microseconds and microseconds into periods; reload shadow at wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre    <= '0;
            r_us     <= '0;
            r_shadow <= THR_W'(PWM_INIT);
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            if (r_us == US_LAST) begin
                r_us     <= '0;
                r_shadow <= i_thres;
            end else begin
                r_us <= r_us + 1'b1;
            end
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Registered pin: high for the first r_shadow microseconds of each period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_pwm <= 1'b0;
        else     o_pwm <= (CMP_W'(r_us) < CMP_W'(r_shadow));
    end
endmodule

// File: rtl/servo_track_axis.sv
// Per-axis closed-loop servo tracker: once per frame converts object position
// and servo feedback into a clamped pulse-width threshold and drives the PWM pin.
module servo_track_axis
    import servo_pkg::*;
#(
    parameter int COORD_W     = 11,
    parameter int IMG_SIZE    = 240,
    parameter int DEADBAND    = 18,
    parameter int GAIN_NUM    = 90,
    parameter int GAIN_SHIFT  = 5,
    parameter int ADC_W       = 12,
    parameter int FB_NUM      = 2380,
    parameter int FB_OFS      = 175,
    parameter int THR_W       = 15,
    parameter int PWM_MIN     = DEF_PWM_MIN,
    parameter int PWM_MAX     = DEF_PWM_MAX,
    parameter int PWM_INIT    = DEF_PWM_INIT,
    parameter int SEARCH_STEP = 20,
    parameter int LOST_HOLD   = 3,
    parameter int CLK_PER_US  = DEF_CLK_PER_US,
    parameter int PERIOD_US   = DEF_PERIOD_US
) (
    input  logic              clk,
    input  logic              rst,
    servo_track_axis_if.slave axis_if
);
    localparam int CW     = THR_W + 2;
    localparam int EW     = COORD_W + 1;
    localparam int FBP_W  = 48;
    localparam int LCNT_W = (LOST_HOLD < 1) ? 1 : $clog2(LOST_HOLD + 1);
    localparam logic signed [EW-1:0] CENTRE_C    = EW'(IMG_SIZE / 2);
    localparam logic [EW-1:0]        DEADBAND_C  = EW'(DEADBAND);
    localparam logic [EW-1:0]        IMG_SIZE_C  = EW'(IMG_SIZE);
    localparam logic [LCNT_W-1:0]    LOST_HOLD_C = LCNT_W'(LOST_HOLD);
    localparam logic signed [CW-1:0] SRCH_C      = CW'(SEARCH_STEP);
    localparam logic signed [CW-1:0] MIN_C       = CW'(PWM_MIN);
    localparam logic signed [CW-1:0] MAX_C       = CW'(PWM_MAX);

    function automatic logic [THR_W-1:0] clamp_thr(input logic signed [CW-1:0] c);
        if (c < MIN_C)      return THR_W'(PWM_MIN);
        else if (c > MAX_C) return THR_W'(PWM_MAX);
        else                return c[THR_W-1:0];
    endfunction

    function automatic logic at_limit(input logic signed [CW-1:0] c);
        return (c <= MIN_C) || (c >= MAX_C);
    endfunction

    logic                     r_vs_s1, r_vs_s2, r_vs_s3, w_frame_stb;
    state_t                   r_state, w_state_nxt;
    logic                     w_sample, w_calc1, w_calc2, w_commit;
    logic                     r_obj_ok, r_fb_vld;
    logic [COORD_W-1:0]       r_coord;
    logic [ADC_W-1:0]         r_fb;
    logic signed [EW-1:0]     w_err, r_err;
    logic [EW-1:0]            w_mag, r_mag;
    logic [FBP_W-1:0]         w_fb_prod;
    logic [THR_W-1:0]         w_fb_base, r_base;
    logic [31:0]              w_step_prod;
    logic signed [CW-1:0]     w_step, w_thr_s, w_base_s, w_cand, r_cand;
    logic                     w_srch_step, r_srch_step;
    logic [THR_W-1:0]         r_thres, w_clamped;
    logic                     w_hit, r_upd, r_searching, r_dir_neg;
    logic [LCNT_W-1:0]        r_lost_cnt, w_lost_nxt;
    logic                     w_pwm;

    // Bring vsync into the clk domain and detect its rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_s1 <= 1'b0;
            r_vs_s2 <= 1'b0;
            r_vs_s3 <= 1'b0;
        end else begin
            r_vs_s1 <= axis_if.vsync;
            r_vs_s2 <= r_vs_s1;
            r_vs_s3 <= r_vs_s2;
        end
    end
    assign w_frame_stb = r_vs_s2 & ~r_vs_s3;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: frame strobes arriving mid-calculation are dropped
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_frame_stb) w_state_nxt = ST_CALC1;
            ST_CALC1: w_state_nxt = ST_CALC2;
            ST_CALC2: w_state_nxt = ST_CLAMP;
            ST_CLAMP: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: per-stage enables for the datapath
    always_comb begin
        w_sample = (r_state == ST_IDLE) && w_frame_stb;
        w_calc1  = (r_state == ST_CALC1);
        w_calc2  = (r_state == ST_CALC2);
        w_commit = (r_state == ST_CLAMP);
    end

    // CALC1 arithmetic: signed error, magnitude and scaled feedback position
    always_comb begin
        w_err     = $signed({1'b0, r_coord}) - CENTRE_C;
        w_mag     = w_err[EW-1] ? $unsigned(-w_err) : $unsigned(w_err);
        w_fb_prod = FBP_W'(r_fb) * FBP_W'(FB_NUM);
        w_fb_base = THR_W'((w_fb_prod >> ADC_W) + FBP_W'(FB_OFS));
    end

    // CALC2 arithmetic: candidate threshold from tracking, hold or search
    always_comb begin
        w_step_prod = 32'(r_mag) * 32'(GAIN_NUM);
        w_step      = $signed(CW'(w_step_prod >> GAIN_SHIFT));
        w_thr_s     = $signed({2'b00, r_thres});
        w_base_s    = $signed({2'b00, r_base});
        w_cand      = w_thr_s;
        w_srch_step = 1'b0;
        if (!r_obj_ok) begin
            if (r_lost_cnt >= LOST_HOLD_C) begin
                w_srch_step = 1'b1;
                w_cand      = r_dir_neg ? (w_thr_s - SRCH_C) : (w_thr_s + SRCH_C);
            end
        end else if (r_mag > DEADBAND_C) begin
            // object left of centre drives the threshold up, right of centre down
            w_cand = r_err[EW-1] ? (w_base_s + w_step) : (w_base_s - w_step);
        end
    end

    // CLAMP arithmetic: limit the candidate and advance the lost-frame count
    always_comb begin
        w_clamped  = clamp_thr(r_cand);
        w_hit      = at_limit(r_cand);
        w_lost_nxt = (r_lost_cnt < LOST_HOLD_C) ? (r_lost_cnt + 1'b1) : r_lost_cnt;
    end

    // Datapath pipeline registers, loaded by the stage enables
    always_ff @(posedge clk) begin
        if (w_sample) begin
            r_obj_ok <= axis_if.obj_valid && ({1'b0, axis_if.obj_coord} < IMG_SIZE_C);
            r_coord  <= axis_if.obj_coord;
            r_fb_vld <= axis_if.fb_valid;
            r_fb     <= axis_if.fb_pos;
        end
        if (w_calc1) begin
            r_err  <= w_err;
            r_mag  <= w_mag;
            r_base <= r_fb_vld ? w_fb_base : r_thres;
        end
        if (w_calc2) begin
            r_cand      <= w_cand;
            r_srch_step <= w_srch_step;
        end
    end

    // Commit threshold, pulse upd and track lost/search state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thres     <= THR_W'(PWM_INIT);
            r_upd       <= 1'b0;
            r_searching <= 1'b0;
            r_lost_cnt  <= '0;
            r_dir_neg   <= 1'b0;
        end else begin
            r_upd <= w_commit;
            if (w_commit) begin
                r_thres <= w_clamped;
                if (r_obj_ok) begin
                    r_lost_cnt  <= '0;
                    r_searching <= 1'b0;
                    r_dir_neg   <= ~r_err[EW-1];
                end else begin
                    r_lost_cnt  <= w_lost_nxt;
                    r_searching <= (w_lost_nxt >= LOST_HOLD_C);
                    // sweep: reverse at a travel limit
                    if (r_srch_step && w_hit) r_dir_neg <= ~r_dir_neg;
                end
            end
        end
    end

    servo_pwm_out #(
        .THR_W      (THR_W),
        .CLK_PER_US (CLK_PER_US),
        .PERIOD_US  (PERIOD_US),
        .PWM_INIT   (PWM_INIT)
    ) u_pwm (
        .clk     (clk),
        .rst     (rst),
        .i_thres (r_thres),
        .o_pwm   (w_pwm)
    );

    assign axis_if.pwm_thres = r_thres;
    assign axis_if.pwm_out   = w_pwm;
    assign axis_if.searching = r_searching;
    assign axis_if.upd       = r_upd;
endmodule
